f1_reaction_ctrl: RTL and testbench
===================================

# f1_reaction_ctrl

Sequencing controller for the F1 starting-light datapath: launches a light sequence, watches the 8-bit light bar, and measures the driver's reaction time in ticks (typically ms, from a clock-tick divider) from lights-out to the reaction button. Sits between the user inputs (start/react flags) and the light top's `trigger`/`data_out`. It detects jump starts, times out slow reactions and keeps a best-time record.

## Interface
- `W`, 16: width of reaction count, result and best registers.
- `MAX_T`, 9999: timeout/saturation count in ticks; must be < 2^W − 1.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  start request (level from vbdFlag); rising edge used.
- `react`  in  1  reaction button (level); rising edge used.
- `tick`  in  1  one-cycle timebase pulse from clock divider.
- `lights`  in  8  light bar from the F1 light top.
- `trigger`  out  1  one-cycle launch pulse to the F1 light top.
- `busy`  out  1  high in ARM, SEQ, HOLD, TIMING.
- `result`  out  W  last measured reaction count.
- `valid`  out  1  one-cycle pulse when `result` is updated.
- `foul`  out  1  jump-start flag, high while in FOUL.
- `timeout`  out  1  high while in DONE if last attempt timed out.
- `best`  out  W  lowest non-timeout result since reset.

## Operation
- Edge detect: `start_q`, `react_q` registers (reset 0); `start_rise = start & ~start_q`, `react_rise = react & ~react_q`.
- States: IDLE, ARM, SEQ, HOLD, TIMING, DONE, FOUL.
- IDLE: `start_rise` → ARM.
- ARM: `trigger`=1 (Moore, exactly one cycle); unconditionally → SEQ.
- SEQ: `react_rise` → FOUL; else `lights == 8'hFF` → HOLD.
- HOLD: `react_rise` → FOUL; else `lights == 8'h00` → TIMING, count cleared to 0.
- TIMING: `react_rise` → DONE, `result` ← count, `valid`=1, `timeout` ← 0, `best` ← count if count < `best`. Else if `tick` and count == MAX_T−1 → DONE, `result` ← MAX_T, `timeout` ← 1, `valid`=1, `best` unchanged. Else if `tick`, count += 1.
- DONE / FOUL: outputs held; `start_rise` → ARM (clears `foul`, `timeout`); `react_rise` ignored.
- `start_rise` in ARM/SEQ/HOLD/TIMING ignored (no restart mid-sequence).
- Count never wraps; it cannot exceed MAX_T.

## Timing
- Reset (rst=0, async): state IDLE; `trigger`, `busy`, `valid`, `foul`, `timeout` = 0; `result` = 0; `best` = all ones; count = 0; edge registers = 0.
- `start` rising at cycle N (sampled) → ARM at N+1, `trigger` high during N+1 only, SEQ at N+2.
- `lights` compared combinationally each cycle; HOLD/TIMING entered on the edge after the matching sample.
- Reaction latency: `react` rising sampled at cycle M in TIMING → `valid` high and `result` updated in cycle M+1.
- Simultaneous `react_rise` and `tick` in TIMING: react wins; count not incremented; result is pre-tick count.
- Simultaneous `react_rise` and `lights == 8'hFF` in SEQ (or `8'h00` in HOLD): FOUL wins.
- Tie with `best`: equal result does not update `best` (strictly less).
- Reset asserted mid-operation: immediate return to reset values; `best` also reset.
- `react` held high through lights-out: no rising edge, so no reaction registered until released and re-pressed; if already high entering SEQ, no foul.

## Test plan
- Reset then idle: rst low 3 cycles, release → all outputs 0, `best` = 16'hFFFF, no `trigger` with start=0 for 50 cycles.
- Normal run: start edge → one-cycle `trigger` 1 cycle later; drive lights 01..FF then 00; 237 ticks then react → `valid` pulse, `result`=237, `best`=237, `busy` 0.
- Jump start: react edge while lights=8'h1F (SEQ) → FOUL, `foul`=1, no `valid`; start edge → `foul` 0, new `trigger`.
- Timeout: lights out, 9999 ticks without react → `result`=9999, `timeout`=1, `valid` pulse, `best` unchanged.
- Best tracking and tie: runs of 300, 200, 200, 250 → `best` 300, 200, 200, 200; react+tick same cycle at count 199 → `result` 199.
- Async reset during TIMING at count 50 → state IDLE immediately, `result` 0, `best` all ones.

Source files
------------

// File: rtl/f1_reaction_if.sv
// Signal bundle between the user inputs / light top and the F1 reaction controller.
// The master modport is the driving side, the slave modport is the controller.
interface f1_reaction_if #(
  parameter int W = 16
);
  logic         start;
  logic         react;
  logic         tick;
  logic [7:0]   lights;
  logic         trigger;
  logic         busy;
  logic [W-1:0] result;
  logic         valid;
  logic         foul;
  logic         timeout;
  logic [W-1:0] best;

  modport master (
    output start, react, tick, lights,
    input  trigger, busy, result, valid, foul, timeout, best
  );

  modport slave (
    input  start, react, tick, lights,
    output trigger, busy, result, valid, foul, timeout, best
  );
endinterface

// File: rtl/f1_reaction_ctrl.sv
// F1 starting-light sequencer: launches the light bar, times lights-out to the
// reaction press, flags jump starts and timeouts, and keeps the best time.
//
// state  | meaning
// IDLE   | waiting for first start edge after reset
// ARM    | one-cycle launch pulse to the light top
// SEQ    | lights filling; waiting for all-on
// HOLD   | all lights on; waiting for lights-out
// TIMING | counting ticks until reaction or timeout
// DONE   | result held until next start edge
// FOUL   | jump start held until next start edge
module f1_reaction_ctrl #(
  parameter int W     = 16,
  parameter int MAX_T = 9999
) (
  input logic          clk,
  input logic          rst,
  f1_reaction_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, ARM, SEQ, HOLD, TIMING, DONE, FOUL
  } state_t;

  localparam logic [W-1:0] MAX_C  = W'(MAX_T);
  localparam logic [W-1:0] LAST_C = W'(MAX_T - 1);

  state_t       state;
  logic         start_q, react_q;
  logic [W-1:0] count;
  logic         trigger_r, busy_r, valid_r, foul_r, timeout_r;
  logic [W-1:0] result_r, best_r;

  logic start_rise, react_rise;
  assign start_rise = bus.start & ~start_q;
  assign react_rise = bus.react & ~react_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      react_q   <= 1'b0;
      count     <= '0;
      trigger_r <= 1'b0;
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      foul_r    <= 1'b0;
      timeout_r <= 1'b0;
      result_r  <= '0;
      best_r    <= '1;
    end else begin
      start_q   <= bus.start;
      react_q   <= bus.react;
      trigger_r <= 1'b0;
      valid_r   <= 1'b0;
      case (state)
        IDLE, DONE, FOUL: begin
          if (start_rise) begin
            state     <= ARM;
            trigger_r <= 1'b1;
            busy_r    <= 1'b1;
            foul_r    <= 1'b0;
            timeout_r <= 1'b0;
          end
        end
        ARM: state <= SEQ;
        SEQ: begin
          // a press during the light sequence beats any light match
          if (react_rise) begin
            state  <= FOUL;
            foul_r <= 1'b1;
            busy_r <= 1'b0;
          end else if (bus.lights == 8'hFF) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (react_rise) begin
            state  <= FOUL;
            foul_r <= 1'b1;
            busy_r <= 1'b0;
          end else if (bus.lights == 8'h00) begin
            state <= TIMING;
            count <= '0;
          end
        end
        TIMING: begin
          if (react_rise) begin
            state     <= DONE;
            result_r  <= count;
            valid_r   <= 1'b1;
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
            if (count < best_r) best_r <= count;
          end else if (bus.tick && count == LAST_C) begin
            state     <= DONE;
            result_r  <= MAX_C;
            valid_r   <= 1'b1;
            timeout_r <= 1'b1;
            busy_r    <= 1'b0;
          end else if (bus.tick) begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.trigger = trigger_r;
  assign bus.busy    = busy_r;
  assign bus.valid   = valid_r;
  assign bus.foul    = foul_r;
  assign bus.timeout = timeout_r;
  assign bus.result  = result_r;
  assign bus.best    = best_r;
endmodule

// File: tb/tb_f1_reaction_ctrl.sv
// Directed bench for f1_reaction_ctrl: a cycle vector table plus hand sequences
// for long timing runs, best tracking, timeout and asynchronous reset.
module tb_f1_reaction_ctrl;
  localparam int W     = 16;
  localparam int MAX_T = 9999;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  f1_reaction_if #(.W(W)) bus ();
  f1_reaction_ctrl #(.W(W), .MAX_T(MAX_T)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic         s, r, t;
    logic [7:0]   l;
    logic         trig, busy, valid, foul, tmo;
    logic [W-1:0] res, best;
  } vec_t;

  int nvec = 0;
  int nerr = 0;

  task automatic do_cycle(input logic s, input logic r, input logic t, input logic [7:0] l);
    @(negedge clk);
    bus.start = s; bus.react = r; bus.tick = t; bus.lights = l;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic trig, input logic busy,
                       input logic valid, input logic foul, input logic tmo,
                       input logic [W-1:0] res, input logic [W-1:0] best);
    nvec++;
    if (bus.trigger !== trig || bus.busy !== busy || bus.valid !== valid ||
        bus.foul !== foul || bus.timeout !== tmo || bus.result !== res || bus.best !== best) begin
      nerr++;
      $display("FAIL %s: got trig=%b busy=%b valid=%b foul=%b tmo=%b res=%0d best=%0d, want trig=%b busy=%b valid=%b foul=%b tmo=%b res=%0d best=%0d",
               name, bus.trigger, bus.busy, bus.valid, bus.foul, bus.timeout, bus.result, bus.best,
               trig, busy, valid, foul, tmo, res, best);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.start = 0; bus.react = 0; bus.tick = 0; bus.lights = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Start edge, one-cycle trigger, lights 01..FF then lights-out; leaves TIMING at count 0.
  task automatic launch(input string name, input logic [W-1:0] res, input logic [W-1:0] best);
    logic [7:0] lv;
    do_cycle(1, 0, 0, 8'h00);
    check({name, "_trig"}, 1, 1, 0, 0, 0, res, best);
    do_cycle(0, 0, 0, 8'h00);
    check({name, "_seq"}, 0, 1, 0, 0, 0, res, best);
    for (int i = 1; i <= 8; i++) begin
      lv = 8'((1 << i) - 1);
      do_cycle(0, 0, 0, lv);
    end
    do_cycle(0, 0, 0, 8'h00);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 1, 8'h00);
  endtask

  // ticks then a press; rt puts a tick in the same cycle as the press
  task automatic attempt(input string name, input int n, input logic rt,
                         input logic [W-1:0] prev_res, input logic [W-1:0] prev_best,
                         input logic [W-1:0] exp_best);
    launch(name, prev_res, prev_best);
    ticks(n);
    do_cycle(0, 1, rt, 8'h00);
    check({name, "_done"}, 0, 0, 1, 0, 0, W'(n), exp_best);
    do_cycle(0, 0, 0, 8'h00);
  endtask

  vec_t vecs[23];
  int trig_seen;

  initial begin
    bus.start = 0; bus.react = 0; bus.tick = 0; bus.lights = 8'h00;

    // reset and idle
    do_reset();
    #1;
    check("reset", 0, 0, 0, 0, 0, 16'd0, 16'hFFFF);
    trig_seen = 0;
    for (int i = 0; i < 50; i++) begin
      do_cycle(0, 0, 0, 8'h00);
      if (bus.trigger || bus.busy) trig_seen++;
    end
    nvec++;
    if (trig_seen != 0) begin
      nerr++;
      $display("FAIL idle_no_trigger: got %0d active cycles, want 0", trig_seen);
    end

    // normal run of 237 ticks
    launch("run237", 16'd0, 16'hFFFF);
    check("run237_timing", 0, 1, 0, 0, 0, 16'd0, 16'hFFFF);
    ticks(237);
    do_cycle(0, 1, 0, 8'h00);
    check("run237_done", 0, 0, 1, 0, 0, 16'd237, 16'd237);
    do_cycle(0, 0, 0, 8'h00);
    check("run237_hold", 0, 0, 0, 0, 0, 16'd237, 16'd237);

    // cycle table from fresh reset
    do_reset();
    //               s  r  t  lights  trg bsy vld ful tmo res best
    vecs[0]  = '{1, 0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 16'hFFFF};
    vecs[1]  = '{1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 16'hFFFF};
    vecs[2]  = '{0, 0, 0, 8'h01, 0, 1, 0, 0, 0, 0, 16'hFFFF};
    vecs[3]  = '{0, 0, 0, 8'hFF, 0, 1, 0, 0, 0, 0, 16'hFFFF};
    vecs[4]  = '{0, 0, 1, 8'hFF, 0, 1, 0, 0, 0, 0, 16'hFFFF};
    vecs[5]  = '{0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 16'hFFFF};
    vecs[6]  = '{0, 0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 16'hFFFF};
    vecs[7]  = '{0, 0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 16'hFFFF};
    vecs[8]  = '{0, 1, 1, 8'h00, 0, 0, 1, 0, 0, 2, 2};
    vecs[9]  = '{0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 2, 2};
    vecs[10] = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 2, 2};
    vecs[11] = '{1, 0, 0, 8'h00, 1, 1, 0, 0, 0, 2, 2};
    vecs[12] = '{0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 2, 2};
    vecs[13] = '{0, 0, 0, 8'h1F, 0, 1, 0, 0, 0, 2, 2};
    vecs[14] = '{0, 1, 0, 8'h1F, 0, 0, 0, 1, 0, 2, 2};
    vecs[15] = '{0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 2, 2};
    vecs[16] = '{1, 0, 0, 8'h00, 1, 1, 0, 0, 0, 2, 2};
    vecs[17] = '{0, 1, 0, 8'h00, 0, 1, 0, 0, 0, 2, 2};
    vecs[18] = '{0, 1, 0, 8'hFF, 0, 1, 0, 0, 0, 2, 2};
    vecs[19] = '{0, 1, 0, 8'h00, 0, 1, 0, 0, 0, 2, 2};
    vecs[20] = '{1, 1, 1, 8'h00, 0, 1, 0, 0, 0, 2, 2};
    vecs[21] = '{0, 0, 1, 8'h00, 0, 1, 0, 0, 0, 2, 2};
    vecs[22] = '{0, 1, 0, 8'h00, 0, 0, 1, 0, 0, 2, 2};
    for (int i = 0; i < 23; i++) begin
      do_cycle(vecs[i].s, vecs[i].r, vecs[i].t, vecs[i].l);
      check($sformatf("vec%0d", i), vecs[i].trig, vecs[i].busy, vecs[i].valid,
            vecs[i].foul, vecs[i].tmo, vecs[i].res, vecs[i].best);
    end
    do_cycle(0, 0, 0, 8'h00);

    // best tracking with a tie, then react and tick together
    do_reset();
    attempt("b300", 300, 0, 16'd0,   16'hFFFF, 16'd300);
    attempt("b200", 200, 0, 16'd300, 16'd300,  16'd200);
    attempt("b200t", 200, 0, 16'd200, 16'd200, 16'd200);
    attempt("b250", 250, 0, 16'd200, 16'd200,  16'd200);
    attempt("rt199", 199, 1, 16'd250, 16'd200, 16'd199);

    // timeout keeps best
    launch("tmo", 16'd199, 16'd199);
    ticks(MAX_T - 1);
    check("tmo_almost", 0, 1, 0, 0, 0, 16'd199, 16'd199);
    do_cycle(0, 0, 1, 8'h00);
    check("tmo_done", 0, 0, 1, 0, 1, 16'(MAX_T), 16'd199);
    do_cycle(0, 1, 1, 8'h00);
    check("tmo_react_ignored", 0, 0, 0, 0, 1, 16'(MAX_T), 16'd199);
    do_cycle(1, 0, 0, 8'h00);
    check("tmo_restart", 1, 1, 0, 0, 0, 16'(MAX_T), 16'd199);
    do_cycle(0, 0, 0, 8'h00);

    // async reset at count 50 in TIMING
    do_reset();
    attempt("pre", 120, 0, 16'd0, 16'hFFFF, 16'd120);
    launch("ar", 16'd120, 16'd120);
    ticks(50);
    check("ar_timing", 0, 1, 0, 0, 0, 16'd120, 16'd120);
    #2 rst = 1'b0;
    #1;
    check("ar_reset", 0, 0, 0, 0, 0, 16'd0, 16'hFFFF);
    @(negedge clk);
    rst = 1'b1;
    do_cycle(0, 0, 1, 8'h00);
    check("ar_idle", 0, 0, 0, 0, 0, 16'd0, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
